keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
Downstream consumer of the 4x4 matrix scanner. It debounces the scanner's key code and key-down flag and turns each stable press into one key event. Digit keys build a 2-digit BCD product code for the vending controller, with enter, clear and backspace keys. The finished code is offered to the controller with a valid/ack handshake.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical clk samples of {key_down,key_value} needed before the input is accepted (>=2)
TIMEOUT_CYCLES, 50_000_000, idle clk cycles before a partial entry is discarded (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
key_down  input  1  high while any row is active (scanner row != 4'b1111); same clk domain
key_value  input  4  scanner key code 0x0-0xF; meaningful only while key_down=1
code_ack  input  1  controller accepts the presented code
code  output  8  BCD product code {tens,units}
code_valid  output  1  code is presented; held until acked
key_event  output  1  one-cycle pulse per accepted press
digit_cnt  output  2  digits currently entered (0-2)
entry_digits  output  8  live BCD entry for the display {d_tens,d_units}
timeout  output  1  one-cycle pulse when a partial entry expires

Behaviour:
- Reset (async, reset=0): all outputs 0; debounce counter 0; accepted state "up"; FSM EMPTY.
- Debounce: register the sample {key_down,key_value} each cycle. If the sample differs from the previous one, the counter clears. When the sample has been identical for DEBOUNCE_CYCLES cycles, it becomes the accepted state.
- key_event pulses for exactly 1 cycle on the cycle after the accepted state changes from up to down. It carries the accepted key code. There is no auto-repeat; a new event needs an accepted release first.
- Key classes: 0x0-0x9 digit; 0xA enter; 0xB clear; 0xC backspace; 0xD-0xF ignored. key_event still pulses for ignored keys.
- FSM states: EMPTY, ONE, TWO, HOLD. Register updates happen on the edge that ends the key_event cycle.
- EMPTY: digit d -> ONE, with entry_digits={0,d}. Enter, clear and backspace are no-ops.
- ONE: digit d -> TWO, entry_digits={units,d} (shift left). Enter -> HOLD with code={0,units}. Clear or backspace -> EMPTY with entry 0.
- TWO: a further digit is ignored. Enter -> HOLD with code=entry_digits. Backspace -> ONE with entry_digits={0,tens}. Clear -> EMPTY.
- HOLD: code_valid=1 and code is stable.
  - On code_ack=1 -> EMPTY next cycle: code_valid=0, entry_digits=0, code retains its last value.
  - All keys in HOLD are ignored except clear, which -> EMPTY and drops code_valid without an ack.
  - code_ack outside HOLD is ignored.
- digit_cnt is 0/1/2 for EMPTY/ONE/TWO and 2 in HOLD, except after a 1-digit enter, where it stays 1.
- Simultaneous code_ack and clear in HOLD: result is EMPTY either way; code_valid drops.
- Reset mid-entry or in HOLD: immediate return to the reset state; no code is emitted.

Optional Feature:
ENTRY_TIMEOUT_EN defined:
- A counter runs in ONE and TWO, and is cleared by every key_event and on every state change.
- When it reaches TIMEOUT_CYCLES-1: FSM -> EMPTY, entry cleared, timeout pulses for 1 cycle.
- The counter is held at 0 in EMPTY and HOLD; HOLD never times out.

ENTRY_TIMEOUT_EN undefined:
- No counter is built; timeout is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package vending_pkg holds:
  - state enum (EMPTY/ONE/TWO/HOLD)
  - key constants KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_BACK=4'hC
  - BCD digit type
- One sub-module, key_debounce, handles sampling, the stable counter and edge detection. It outputs key_event and the accepted code.
- The FSM and entry registers stay in keypad_entry.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: key_down=1, key_value=3 held 4 cycles -> key_event pulses once, entry_digits=0x03, digit_cnt=1. Holding 100 more cycles gives no further events.
- Bounce: key toggles every 2 cycles for 20 cycles, then holds 7 -> exactly 1 key_event; entry_digits=0x07.
- Entry and handshake: presses 4,2,A -> code=0x42, code_valid=1. code_valid stays 1 for 10 cycles without ack. One cycle of code_ack -> code_valid=0, digit_cnt=0.
- Editing:
  - 1,2,C,5,A -> code=0x15.
  - 9,A -> code=0x09.
  - 7,8,9 -> entry_digits=0x78.
  - A in EMPTY -> no code_valid.
  - B in HOLD -> code_valid=0 with no ack.
- Reset: reset=0 asserted mid-press and in HOLD -> all outputs 0 immediately. After release, a held key produces an event only after 4 stable cycles.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20: press 5, then idle 20 cycles -> timeout pulse, digit_cnt=0. In HOLD, idle 40 cycles -> code_valid stays 1.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and key codes for the keypad entry path of the vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        HOLD  = 2'd3
    } entry_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t KEY_ENTER = 4'hA;
    localparam bcd_t KEY_CLEAR = 4'hB;
    localparam bcd_t KEY_BACK  = 4'hC;

    function automatic logic is_digit(bcd_t k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Product-code handshake between keypad entry (master) and the vending controller (slave).
interface keypad_entry_if;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ack;

    modport master (output code, output code_valid, input code_ack);
    modport slave  (input code, input code_valid, output code_ack);
endinterface

// File: rtl/key_debounce.sv
// Debounces {key_down,key_value} and emits one key_event per accepted press.
import vending_pkg::*;

module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_down,
    input  bcd_t key_value,
    output logic key_event,
    output bcd_t key_code
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_CYCLES - 2);

    logic [4:0]    samp_in;
    logic [4:0]    samp_q;
    logic [CW-1:0] cnt;
    logic          acc_down;

    assign samp_in = {key_down, key_value};

    // cnt counts repeats of samp_q; the sample that loads samp_q is the first of the run
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q    <= '0;
            cnt       <= '0;
            acc_down  <= 1'b0;
            key_event <= 1'b0;
            key_code  <= '0;
        end else begin
            samp_q    <= samp_in;
            key_event <= 1'b0;
            if (samp_in != samp_q) begin
                cnt <= '0;
            end else begin
                if (cnt != CNT_SAT)
                    cnt <= cnt + 1'b1;
                if (cnt >= CNT_ACC) begin
                    acc_down <= samp_in[4];
                    if (samp_in[4] && !acc_down) begin
                        key_event <= 1'b1;
                        key_code  <= samp_in[3:0];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Two-digit BCD product-code entry with enter/clear/backspace and valid/ack handoff.
// Optional partial-entry expiry is built when ENTRY_TIMEOUT_EN is defined.
//
// state | meaning
// EMPTY | no digits entered
// ONE   | one digit entered (units)
// TWO   | two digits entered (tens, units)
// HOLD  | code presented, waiting for code_ack or clear
import vending_pkg::*;

module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_down,
    input  bcd_t                  key_value,
    keypad_entry_if.master        code_if,
    output logic                  key_event,
    output logic [1:0]            digit_cnt,
    output logic [7:0]            entry_digits,
    output logic                  timeout
);

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("keypad_entry: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
    end

    entry_state_t state;
    bcd_t         key_code;
    logic [7:0]   code_q;
    logic         code_valid_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_down  (key_down),
        .key_value (key_value),
        .key_event (key_event),
        .key_code  (key_code)
    );

    assign code_if.code       = code_q;
    assign code_if.code_valid = code_valid_q;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= EMPTY;
            entry_digits <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            digit_cnt    <= '0;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt     <= '0;
            timeout      <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (key_event && is_digit(key_code)) begin
                        state        <= ONE;
                        entry_digits <= {4'd0, key_code};
                        digit_cnt    <= 2'd1;
                    end
                end
                ONE: begin
                    if (key_event) begin
                        if (is_digit(key_code)) begin
                            state        <= TWO;
                            entry_digits <= {entry_digits[3:0], key_code};
                            digit_cnt    <= 2'd2;
                        end else if (key_code == KEY_ENTER) begin
                            state        <= HOLD;
                            code_q       <= {4'd0, entry_digits[3:0]};
                            code_valid_q <= 1'b1;
                        end else if (key_code == KEY_CLEAR || key_code == KEY_BACK) begin
                            state        <= EMPTY;
                            entry_digits <= '0;
                            digit_cnt    <= 2'd0;
                        end
                    end
                end
                TWO: begin
                    if (key_event) begin
                        if (key_code == KEY_ENTER) begin
                            state        <= HOLD;
                            code_q       <= entry_digits;
                            code_valid_q <= 1'b1;
                        end else if (key_code == KEY_BACK) begin
                            state        <= ONE;
                            entry_digits <= {4'd0, entry_digits[7:4]};
                            digit_cnt    <= 2'd1;
                        end else if (key_code == KEY_CLEAR) begin
                            state        <= EMPTY;
                            entry_digits <= '0;
                            digit_cnt    <= 2'd0;
                        end
                    end
                end
                HOLD: begin
                    // code_q keeps its last value after the handoff
                    if (code_if.code_ack || (key_event && key_code == KEY_CLEAR)) begin
                        state        <= EMPTY;
                        entry_digits <= '0;
                        code_valid_q <= 1'b0;
                        digit_cnt    <= 2'd0;
                    end
                end
                default: state <= EMPTY;
            endcase

`ifdef ENTRY_TIMEOUT_EN
            // Every exit from ONE/TWO is key-driven, so key_event also covers state-change clears
            timeout <= 1'b0;
            if (state == ONE || state == TWO) begin
                if (key_event) begin
                    idle_cnt <= '0;
                end else if (idle_cnt == TO_MAX) begin
                    state        <= EMPTY;
                    entry_digits <= '0;
                    digit_cnt    <= 2'd0;
                    timeout      <= 1'b1;
                    idle_cnt     <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_keypad_entry;

    logic       clk;
    logic       reset;
    logic       key_down;
    logic [3:0] key_value;
    logic       key_event;
    logic [1:0] digit_cnt;
    logic [7:0] entry_digits;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;
    int to_cnt = 0;

    keypad_entry_if cif ();

    keypad_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_down     (key_down),
        .key_value    (key_value),
        .code_if      (cif),
        .key_event    (key_event),
        .digit_cnt    (digit_cnt),
        .entry_digits (entry_digits),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event) ev_cnt++;
        if (timeout)   to_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_down  = 1'b1;
        key_value = k;
        tick(6);
        key_down  = 1'b0;
        key_value = 4'h0;
        tick(6);
    endtask

    task automatic ack_pulse();
        cif.code_ack = 1'b1;
        tick(1);
        cif.code_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_down = 1'b0;
        key_value = 4'h0;
        cif.code_ack = 1'b0;
        tick(3);
        total++;
        if ({cif.code, cif.code_valid, key_event, digit_cnt, entry_digits, timeout} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got code=%h valid=%b ev=%b cnt=%0d entry=%h to=%b, expected all 0",
                     cif.code, cif.code_valid, key_event, digit_cnt, entry_digits, timeout);
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_clean_press();
        int ev0;
        ev0 = ev_cnt;
        key_down = 1'b1;
        key_value = 4'h3;
        tick(3);
        total++;
        if (key_event !== 1'b0) begin
            bad++;
            $display("FAIL clean_early_event: got %b expected 0", key_event);
        end
        tick(1);
        total++;
        if (key_event !== 1'b1) begin
            bad++;
            $display("FAIL clean_event_4th: got %b expected 1", key_event);
        end
        tick(2);
        total++;
        if (entry_digits !== 8'h03 || digit_cnt !== 2'd1) begin
            bad++;
            $display("FAIL clean_entry: got entry=%h cnt=%0d expected 03/1", entry_digits, digit_cnt);
        end
        tick(100);
        total++;
        if (ev_cnt - ev0 !== 1) begin
            bad++;
            $display("FAIL clean_no_repeat: got %0d events expected 1", ev_cnt - ev0);
        end
        key_down = 1'b0;
        key_value = 4'h0;
        tick(6);
        press(4'hB);
        total++;
        if (entry_digits !== 8'h00 || digit_cnt !== 2'd0) begin
            bad++;
            $display("FAIL clean_clear: got entry=%h cnt=%0d expected 00/0", entry_digits, digit_cnt);
        end
    endtask

    task automatic test_bounce();
        int ev0;
        ev0 = ev_cnt;
        for (int i = 0; i < 10; i++) begin
            key_down = (i % 2 == 0);
            key_value = 4'h7;
            tick(2);
        end
        key_down = 1'b1;
        key_value = 4'h7;
        tick(7);
        key_down = 1'b0;
        key_value = 4'h0;
        tick(6);
        total++;
        if (ev_cnt - ev0 !== 1) begin
            bad++;
            $display("FAIL bounce_events: got %0d expected 1", ev_cnt - ev0);
        end
        total++;
        if (entry_digits !== 8'h07) begin
            bad++;
            $display("FAIL bounce_entry: got %h expected 07", entry_digits);
        end
        press(4'hB);
    endtask

    task automatic test_handshake();
        press(4'h4);
        press(4'h2);
        press(4'hA);
        total++;
        if (cif.code !== 8'h42 || cif.code_valid !== 1'b1 || digit_cnt !== 2'd2) begin
            bad++;
            $display("FAIL hs_present: got code=%h valid=%b cnt=%0d expected 42/1/2",
                     cif.code, cif.code_valid, digit_cnt);
        end
        tick(10);
        total++;
        if (cif.code !== 8'h42 || cif.code_valid !== 1'b1) begin
            bad++;
            $display("FAIL hs_hold: got code=%h valid=%b expected 42/1", cif.code, cif.code_valid);
        end
        ack_pulse();
        total++;
        if (cif.code_valid !== 1'b0 || digit_cnt !== 2'd0 || entry_digits !== 8'h00 || cif.code !== 8'h42) begin
            bad++;
            $display("FAIL hs_ack: got valid=%b cnt=%0d entry=%h code=%h expected 0/0/00/42",
                     cif.code_valid, digit_cnt, entry_digits, cif.code);
        end
    endtask

    task automatic test_editing();
        press(4'h1); press(4'h2); press(4'hC); press(4'h5); press(4'hA);
        total++;
        if (cif.code !== 8'h15 || cif.code_valid !== 1'b1) begin
            bad++;
            $display("FAIL edit_back: got code=%h valid=%b expected 15/1", cif.code, cif.code_valid);
        end
        ack_pulse();
        press(4'h9); press(4'hA);
        total++;
        if (cif.code !== 8'h09 || cif.code_valid !== 1'b1 || digit_cnt !== 2'd1) begin
            bad++;
            $display("FAIL edit_one_digit: got code=%h valid=%b cnt=%0d expected 09/1/1",
                     cif.code, cif.code_valid, digit_cnt);
        end
        ack_pulse();
        press(4'h7); press(4'h8); press(4'h9);
        total++;
        if (entry_digits !== 8'h78 || digit_cnt !== 2'd2) begin
            bad++;
            $display("FAIL edit_third_digit: got entry=%h cnt=%0d expected 78/2", entry_digits, digit_cnt);
        end
        press(4'hB);
        press(4'h6); press(4'hC);
        total++;
        if (entry_digits !== 8'h00 || digit_cnt !== 2'd0) begin
            bad++;
            $display("FAIL edit_back_one: got entry=%h cnt=%0d expected 00/0", entry_digits, digit_cnt);
        end
        press(4'hA);
        ack_pulse();
        press(4'hE);
        total++;
        if (cif.code_valid !== 1'b0 || digit_cnt !== 2'd0 || entry_digits !== 8'h00) begin
            bad++;
            $display("FAIL edit_empty_noop: got valid=%b cnt=%0d entry=%h expected 0/0/00",
                     cif.code_valid, digit_cnt, entry_digits);
        end
        press(4'h3); press(4'hA); press(4'h5);
        total++;
        if (cif.code !== 8'h03 || cif.code_valid !== 1'b1) begin
            bad++;
            $display("FAIL edit_hold_ignore: got code=%h valid=%b expected 03/1", cif.code, cif.code_valid);
        end
        press(4'hB);
        total++;
        if (cif.code_valid !== 1'b0 || digit_cnt !== 2'd0 || cif.code !== 8'h03) begin
            bad++;
            $display("FAIL edit_hold_clear: got valid=%b cnt=%0d code=%h expected 0/0/03",
                     cif.code_valid, digit_cnt, cif.code);
        end
    endtask

    task automatic test_reset_mid();
        int ev0;
        key_down = 1'b1;
        key_value = 4'h5;
        tick(2);
        reset = 1'b0;
        #1;
        total++;
        if ({key_event, digit_cnt, entry_digits, cif.code_valid} !== 12'h0) begin
            bad++;
            $display("FAIL rst_mid_press: got ev=%b cnt=%0d entry=%h valid=%b expected 0",
                     key_event, digit_cnt, entry_digits, cif.code_valid);
        end
        key_down = 1'b0;
        key_value = 4'h0;
        tick(2);
        reset = 1'b1;
        tick(2);
        press(4'h4); press(4'hA);
        reset = 1'b0;
        #1;
        total++;
        if ({cif.code, cif.code_valid, digit_cnt, entry_digits} !== 19'h0) begin
            bad++;
            $display("FAIL rst_in_hold: got code=%h valid=%b cnt=%0d entry=%h expected 0",
                     cif.code, cif.code_valid, digit_cnt, entry_digits);
        end
        key_down = 1'b1;
        key_value = 4'h6;
        tick(2);
        reset = 1'b1;
        ev0 = ev_cnt;
        tick(3);
        total++;
        if (ev_cnt - ev0 !== 0) begin
            bad++;
            $display("FAIL rst_early_event: got %0d events expected 0", ev_cnt - ev0);
        end
        tick(3);
        total++;
        if (ev_cnt - ev0 !== 1 || entry_digits !== 8'h06) begin
            bad++;
            $display("FAIL rst_held_key: got %0d events entry=%h expected 1/06", ev_cnt - ev0, entry_digits);
        end
        key_down = 1'b0;
        key_value = 4'h0;
        tick(6);
        press(4'hB);
    endtask

    task automatic test_ack_outside_hold();
        press(4'h2);
        ack_pulse();
        total++;
        if (digit_cnt !== 2'd1 || entry_digits !== 8'h02 || cif.code_valid !== 1'b0) begin
            bad++;
            $display("FAIL ack_ignored: got cnt=%0d entry=%h valid=%b expected 1/02/0",
                     digit_cnt, entry_digits, cif.code_valid);
        end
        press(4'hB);
    endtask

`ifdef ENTRY_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int to0;
        to0 = to_cnt;
        press(4'h5);
        n = 0;
        while (to_cnt == to0 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (to_cnt - to0 !== 1 || digit_cnt !== 2'd0 || entry_digits !== 8'h00) begin
            bad++;
            $display("FAIL timeout_partial: got pulses=%0d cnt=%0d entry=%h expected 1/0/00",
                     to_cnt - to0, digit_cnt, entry_digits);
        end
        press(4'h3); press(4'hA);
        tick(40);
        total++;
        if (cif.code_valid !== 1'b1 || to_cnt - to0 !== 1) begin
            bad++;
            $display("FAIL timeout_hold: got valid=%b pulses=%0d expected 1/1", cif.code_valid, to_cnt - to0);
        end
        ack_pulse();
    endtask
`else
    task automatic test_timeout();
        press(4'h5);
        tick(60);
        total++;
        if (to_cnt !== 0 || digit_cnt !== 2'd1) begin
            bad++;
            $display("FAIL no_timeout: got pulses=%0d cnt=%0d expected 0/1", to_cnt, digit_cnt);
        end
        press(4'hB);
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_handshake();
        test_editing();
        test_reset_mid();
        test_ack_outside_hold();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
